// File: rtl/abrutech_serial_pkg.sv
// abrutech_serial_pkg: FSM encodings and default widths shared by serial_parallel and parallel_serial
package abrutech_serial_pkg;
  localparam int DEF_PARALLEL_PORT_WIDTH = 15;
  localparam int DEF_BIT_LENGTH = 4;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1
  } serial_state_e;
endpackage

// File: rtl/serial_parallel_if.sv
// serial_parallel_if: serial line in, assembled word out
//   din        serial line, idle high, start bit 0, data LSB first
//   bit_length data bits per frame
//   dout       assembled word
//   dv_out     one-cycle dout valid pulse
//   rx_busy    receiving a frame (only with SERIAL_PARALLEL_BUSY_EN)
interface serial_parallel_if
  import abrutech_serial_pkg::*;
#(
  parameter int PARALLEL_PORT_WIDTH = DEF_PARALLEL_PORT_WIDTH,
  parameter int BIT_LENGTH = DEF_BIT_LENGTH
);
  logic din;
  logic [BIT_LENGTH-1:0] bit_length;
  logic [PARALLEL_PORT_WIDTH-1:0] dout;
  logic dv_out;
`ifdef SERIAL_PARALLEL_BUSY_EN
  logic rx_busy;
  modport master (output din, bit_length, input dout, dv_out, rx_busy);
  modport slave (input din, bit_length, output dout, dv_out, rx_busy);
`else
  modport master (output din, bit_length, input dout, dv_out);
  modport slave (input din, bit_length, output dout, dv_out);
`endif
endinterface

// File: rtl/serial_parallel.sv
// serial_parallel: serial-to-parallel receiver (start bit 0, data LSB first, one bit per clk)
//   clk   clock, rising edge
//   rstn  asynchronous active-low reset
//   sp    serial_parallel_if.slave: din, bit_length in; dout, dv_out (and rx_busy) out
//   SERIAL_PARALLEL_BUSY_EN adds sp.rx_busy, high while receiving
module serial_parallel
  import abrutech_serial_pkg::*;
#(
  parameter int PARALLEL_PORT_WIDTH = DEF_PARALLEL_PORT_WIDTH,
  parameter int BIT_LENGTH = DEF_BIT_LENGTH
) (
  input logic clk,
  input logic rstn,
  serial_parallel_if.slave sp
);
  serial_state_e state_q, state_d;
  logic [BIT_LENGTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [PARALLEL_PORT_WIDTH-1:0] buf_q, buf_d, dout_q, dout_d;
  logic dv_q, dv_d, start, done;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    start = state_q == IDLE && !sp.din && sp.bit_length != '0;
    done = state_q == RECEIVE && cnt_q == len_q - 1'b1;
    state_d = start ? RECEIVE : done ? IDLE : state_q;
  end
  // dout is loaded from buf_d so the final data bit lands in the same edge
  always_comb begin
    cnt_d = start ? '0 : state_q == RECEIVE ? cnt_q + 1'b1 : cnt_q;
    len_d = start ? sp.bit_length : len_q;
    buf_d = start ? '0 : buf_q;
    if (state_q == RECEIVE && int'(cnt_q) < PARALLEL_PORT_WIDTH) buf_d[cnt_q] = sp.din;
    dout_d = done ? buf_d : dout_q;
    dv_d = done;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt_q <= '0;
      len_q <= '0;
      buf_q <= '0;
      dout_q <= '0;
      dv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
      buf_q <= buf_d;
      dout_q <= dout_d;
      dv_q <= dv_d;
    end
  assign sp.dout = dout_q;
  assign sp.dv_out = dv_q;
`ifdef SERIAL_PARALLEL_BUSY_EN
  assign sp.rx_busy = state_q == RECEIVE;
`else
`endif
endmodule
